sram_port_scheduler: RTL

Round-robin command scheduler and read-return router for the shared SRAM port. It sits on the sram_clock side of the clock-crossing FIFOs, between two write-command FIFOs (W0, W1), two read-address FIFOs (R0, R1), the SRAM controller command interface, and the two read-data FIFOs. Each read is tagged with its requester, so returning data is steered to the correct data FIFO. Per-reader credits guarantee a read is never issued without space for its data.

---
 rtl/sram_sched_pkg.sv | 31 +++
 rtl/sram_tag_fifo.sv | 50 +++++
 rtl/sram_port_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sram_sched_pkg.sv
// Shared constants for the SRAM port scheduler: port identifiers, default
// widths and the bit offsets of the packed {mask,addr,data} write command.
package sram_sched_pkg;

  localparam int DEF_ADDR_W          = 18;
  localparam int DEF_DATA_W          = 32;
  localparam int DEF_MASK_W          = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;
  localparam int DEF_DFIFO_CREDITS   = 16;

  // Port ids, also the encoding reported on grant_state.
  localparam logic [2:0] PORT_IDLE = 3'd0;
  localparam logic [2:0] PORT_W0   = 3'd1;
  localparam logic [2:0] PORT_W1   = 3'd2;
  localparam logic [2:0] PORT_R0   = 3'd3;
  localparam logic [2:0] PORT_R1   = 3'd4;

  // Field offsets inside a write command word {mask, addr, data}.
  function automatic int cmd_data_lsb();
    return 0;
  endfunction

  function automatic int cmd_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int cmd_mask_lsb(input int data_w, input int addr_w);
    return data_w + addr_w;
  endfunction

endpackage

// File: rtl/sram_tag_fifo.sv
// One-bit-wide requester tag FIFO for reads in flight. Push and pop in the
// same cycle are both honoured: a pop frees the slot a full-FIFO push needs,
// and a pop on an empty FIFO is ignored. DEPTH must be a power of two >= 2.
module sram_tag_fifo
  import sram_sched_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra msb distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Tag storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sram_port_scheduler.sv
// Round-robin scheduler for the shared SRAM port (W0, W1, R0, R1) with
// tagged read-return routing and per-reader data-FIFO credits.
//
// Handshake: a command is held on sram_addr/sram_data_in/sram_write_mask
// while sram_addr_valid=1 and is consumed on a clock edge where
// sram_ready=1; outputs never change while valid=1 and ready=0. Source FIFOs
// are first-word-fall-through: wN/rN_valid means the head is present, and
// the rd_en pulse pops it in the same cycle the command is captured.
module sram_port_scheduler
  import sram_sched_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int MASK_W          = DEF_MASK_W,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int DFIFO_CREDITS   = DEF_DFIFO_CREDITS
) (
  input  logic                            sram_clock,
  input  logic                            reset,
  input  logic                            w0_valid,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0] w0_cmd,
  output logic                            w0_rd_en,
  input  logic                            w1_valid,
  input  logic [MASK_W+ADDR_W+DATA_W-1:0] w1_cmd,
  output logic                            w1_rd_en,
  input  logic                            r0_valid,
  input  logic [ADDR_W-1:0]               r0_addr,
  output logic                            r0_rd_en,
  input  logic                            r1_valid,
  input  logic [ADDR_W-1:0]               r1_addr,
  output logic                            r1_rd_en,
  input  logic                            r0_credit,
  input  logic                            r1_credit,
  output logic                            sram_addr_valid,
  input  logic                            sram_ready,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [DATA_W-1:0]               sram_data_in,
  output logic [MASK_W-1:0]               sram_write_mask,
  input  logic                            sram_data_out_valid,
  input  logic [DATA_W-1:0]               sram_data_out,
  output logic                            r0_data_wr_en,
  output logic                            r1_data_wr_en,
  output logic [DATA_W-1:0]               r_data,
  output logic [2:0]                      grant_state,
  output logic                            err_orphan_data
);

  localparam int DATA_LSB = cmd_data_lsb();
  localparam int ADDR_LSB = cmd_addr_lsb(DATA_W);
  localparam int MASK_LSB = cmd_mask_lsb(DATA_W, ADDR_W);
  localparam int CRED_W   = $clog2(DFIFO_CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(DFIFO_CREDITS);
  localparam logic [CRED_W-1:0] CRED_ONE = {{(CRED_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Internal port index: 0=W0, 1=W1, 2=R0, 3=R1 (bit 1 set means read).
  logic [0:0]        state;
  logic [1:0]        last_grant;
  logic [1:0]        held_port;
  logic [CRED_W-1:0] credits [2];
  logic [1:0]        cred_dec;
  logic [1:0]        cred_inc;
  logic [3:0]        elig;
  logic [1:0]        winner;
  logic              grant;
  logic              grant_read;
  logic              tag_full;
  logic              tag_empty;
  logic              tag_head;
  logic              tag_pop;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;
  logic [MASK_W-1:0] next_mask;

  // Readers need a free data-FIFO slot and a free tag slot to be eligible.
  always_comb begin
    elig[0] = w0_valid;
    elig[1] = w1_valid;
    elig[2] = r0_valid && (credits[0] != '0) && !tag_full;
    elig[3] = r1_valid && (credits[1] != '0) && !tag_full;
  end

  // First eligible port after last_grant; scanning downwards lets the nearest win.
  always_comb begin
    winner = last_grant;
    for (int k = 4; k >= 1; k--) begin
      if (elig[last_grant + 2'(k)]) winner = last_grant + 2'(k);
    end
  end

  assign grant      = reset && (elig != 4'b0000) && ((state == ST_IDLE) || sram_ready);
  assign grant_read = grant && winner[1];
  assign w0_rd_en   = grant && (winner == 2'd0);
  assign w1_rd_en   = grant && (winner == 2'd1);
  assign r0_rd_en   = grant && (winner == 2'd2);
  assign r1_rd_en   = grant && (winner == 2'd3);

  // Command selected for capture; reads carry mask 0 and data 0.
  always_comb begin
    next_addr = '0;
    next_data = '0;
    next_mask = '0;
    case (winner)
      2'd0: begin
        next_mask = w0_cmd[MASK_LSB +: MASK_W];
        next_addr = w0_cmd[ADDR_LSB +: ADDR_W];
        next_data = w0_cmd[DATA_LSB +: DATA_W];
      end
      2'd1: begin
        next_mask = w1_cmd[MASK_LSB +: MASK_W];
        next_addr = w1_cmd[ADDR_LSB +: ADDR_W];
        next_data = w1_cmd[DATA_LSB +: DATA_W];
      end
      2'd2:    next_addr = r0_addr;
      default: next_addr = r1_addr;
    endcase
  end

  // IDLE/HOLD control and the held command registers.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      last_grant      <= 2'd3;
      held_port       <= 2'd0;
      sram_addr       <= '0;
      sram_data_in    <= '0;
      sram_write_mask <= '0;
    end else if (grant) begin
      state           <= ST_HOLD;
      last_grant      <= winner;
      held_port       <= winner;
      sram_addr       <= next_addr;
      sram_data_in    <= next_data;
      sram_write_mask <= next_mask;
    end else if ((state == ST_HOLD) && sram_ready) begin
      state           <= ST_IDLE;
      held_port       <= 2'd0;
      sram_addr       <= '0;
      sram_data_in    <= '0;
      sram_write_mask <= '0;
    end
  end

  assign sram_addr_valid = (state == ST_HOLD);
  assign grant_state     = (state == ST_HOLD) ? (PORT_W0 + {1'b0, held_port}) : PORT_IDLE;

  assign cred_dec = {grant_read && winner[0], grant_read && !winner[0]};
  assign cred_inc = {r1_credit, r0_credit};

  // Credit counters: grant takes one, credit pulse returns one, capped at the FIFO depth.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      credits[0] <= CRED_MAX;
      credits[1] <= CRED_MAX;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cred_dec[i] && !cred_inc[i]) begin
          credits[i] <= credits[i] - CRED_ONE;
        end else if (!cred_dec[i] && cred_inc[i] && (credits[i] != CRED_MAX)) begin
          credits[i] <= credits[i] + CRED_ONE;
        end
      end
    end
  end

  sram_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (sram_clock),
    .rst_n (reset),
    .push  (grant_read),
    .din   (winner[0]),
    .pop   (sram_data_out_valid),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Return data is steered by the oldest outstanding tag with no added latency.
  assign tag_pop       = sram_data_out_valid && !tag_empty;
  assign r0_data_wr_en = tag_pop && !tag_head;
  assign r1_data_wr_en = tag_pop && tag_head;
  assign r_data        = sram_data_out;

  // Sticky flag for data that arrives with nothing outstanding.
  always_ff @(posedge sram_clock or negedge reset) begin
    if (!reset) begin
      err_orphan_data <= 1'b0;
    end else if (sram_data_out_valid && tag_empty) begin
      err_orphan_data <= 1'b1;
    end
  end

endmodule
